// File: rtl/se_pkg.sv
// Shared types and elaboration-time helpers for the squeeze-excite global average pool.
package se_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } pool_state_t;

  // round(2^16 / pixels), evaluated once at elaboration
  function automatic int calc_recip(input int pixels);
    return (32'sd65536 + (pixels / 32'sd2)) / pixels;
  endfunction

endpackage

// File: rtl/se_gap_scaler.sv
// Turns a channel sum into its average: reciprocal multiply, round half up, saturate.
module se_gap_scaler #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 22,
  parameter int RECIP      = 1337
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] avg
);

  // Headroom for the 17-bit reciprocal plus the rounding add
  localparam int PW = ACC_WIDTH + 19;
  localparam logic signed [PW-1:0] RECIP_EXT = PW'(RECIP);
  localparam logic signed [PW-1:0] HALF      = PW'(32768);
  localparam logic signed [PW-1:0] MAX_V = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] product_s;
  logic signed [PW-1:0] rounded_s;

  // Scale, round and clamp into the output range
  always_comb begin
    product_s = PW'(acc) * RECIP_EXT;
    rounded_s = (product_s + HALF) >>> 16;
    if (rounded_s > MAX_V) begin
      avg = MAX_V[DATA_WIDTH-1:0];
    end else if (rounded_s < MIN_V) begin
      avg = MIN_V[DATA_WIDTH-1:0];
    end else begin
      avg = rounded_s[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/se_global_avg_pool.sv
// Global average pool over an HxW feature map, channel-interleaved in, one average per channel out.
module se_global_avg_pool
  import se_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CHANNELS   = 16,
  parameter int HEIGHT     = 7,
  parameter int WIDTH      = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int PIXELS    = HEIGHT * WIDTH;
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(PIXELS);
  localparam int RECIP     = calc_recip(PIXELS);
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PIX_W     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  pool_state_t                  state_r;
  logic signed [ACC_WIDTH-1:0]  acc_r [CHANNELS];
  logic [CH_W-1:0]              ch_idx_r;
  logic [PIX_W-1:0]             pix_cnt_r;
  logic [CH_W-1:0]              out_ch_r;
  logic                         in_ready_r;
  logic                         out_valid_r;
  logic                         out_last_r;
  logic signed [DATA_WIDTH-1:0] out_data_r;

  logic                         accept_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic [CH_W-1:0]              next_ch_s;
  logic [CH_W-1:0]              rd_idx_s;
  logic signed [ACC_WIDTH-1:0]  scale_in_s;
  logic signed [DATA_WIDTH-1:0] scaled_s;

  // Single shared adder and the read port feeding the scaler
  always_comb begin
    accept_s  = in_valid && in_ready_r && (state_r == ST_ACCUM);
    sum_s     = acc_r[ch_idx_r] + ACC_WIDTH'(in_data);
    next_ch_s = out_ch_r + 1'b1;
    if (state_r == ST_EMIT) begin
      rd_idx_s = next_ch_s;
    end else begin
      rd_idx_s = '0;
    end
    // With one channel, channel 0 is still being written on the final accept
    if (accept_s && (ch_idx_r == rd_idx_s)) begin
      scale_in_s = sum_s;
    end else begin
      scale_in_s = acc_r[rd_idx_s];
    end
  end

  se_gap_scaler #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .RECIP     (RECIP)
  ) u_scaler (
    .acc(scale_in_s),
    .avg(scaled_s)
  );

  // Pool FSM: accumulate a full frame, then emit one average per channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_ACCUM;
      ch_idx_r    <= '0;
      pix_cnt_r   <= '0;
      out_ch_r    <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_ACCUM: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            acc_r[ch_idx_r] <= sum_s;
            if (ch_idx_r == CH_LAST) begin
              ch_idx_r <= '0;
              if (pix_cnt_r == PIX_LAST) begin
                pix_cnt_r   <= '0;
                state_r     <= ST_EMIT;
                in_ready_r  <= 1'b0;
                out_valid_r <= 1'b1;
                out_data_r  <= scaled_s;
                out_last_r  <= (CHANNELS == 1);
                out_ch_r    <= '0;
              end else begin
                pix_cnt_r <= pix_cnt_r + 1'b1;
              end
            end else begin
              ch_idx_r <= ch_idx_r + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (out_last_r) begin
              state_r     <= ST_ACCUM;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_data_r  <= '0;
              out_ch_r    <= '0;
              ch_idx_r    <= '0;
              pix_cnt_r   <= '0;
              for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= '0;
              end
            end else begin
              out_ch_r   <= next_ch_s;
              out_data_r <= scaled_s;
              out_last_r <= (next_ch_s == CH_LAST);
            end
          end
        end
        default: begin
          state_r     <= ST_ACCUM;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_se_global_avg_pool.sv
// Directed bench for se_global_avg_pool with a frame-level average model and a per-cycle output checker.
module tb_se_global_avg_pool;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;

  int checks = 0;
  int errors = 0;

  int exp_data_q[$];
  bit exp_last_q[$];
  int got_q[$];

  logic signed [DW-1:0] f0[4];
  logic signed [DW-1:0] f1[4];

  bit stall_seen = 0;
  bit prev_last_hs = 0;
  logic signed [DW-1:0] held_data;
  logic held_last;

  se_global_avg_pool #(
    .DATA_WIDTH(DW), .CHANNELS(2), .HEIGHT(2), .WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Average of a 4-pixel channel sum: round-to-nearest, halves toward +inf, clamped
  function automatic int avg_model(input longint sum);
    longint r;
    r = (sum * 64'sd65536 / 64'sd4 + 64'sd32768) >>> 16;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Output checker: scoreboard compare, stability under stall, exclusivity of ready/valid
  always @(negedge clk) begin
    if (!rst) begin
      stall_seen   = 0;
      prev_last_hs = 0;
    end else begin
      if (prev_last_hs) begin
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
        prev_last_hs = 0;
      end
      if (out_valid) begin
        check("in_ready_during_emit", in_ready, 0);
        if (stall_seen) begin
          check("stall_data_stable", out_data, held_data);
          check("stall_last_stable", out_last, held_last);
        end
        if (out_ready) begin
          stall_seen = 0;
          if (exp_data_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %0d, expected none", out_data);
          end else begin
            check("out_data", out_data, exp_data_q.pop_front());
            check("out_last", out_last, exp_last_q.pop_front());
            got_q.push_back(int'(out_data));
          end
          prev_last_hs = out_last;
        end else begin
          stall_seen = 1;
          held_data  = out_data;
          held_last  = out_last;
        end
      end else begin
        stall_seen = 0;
      end
    end
  end

  task automatic send_sample(input logic signed [DW-1:0] v);
    bit ok;
    ok = 0;
    in_data  = v;
    in_valid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no in_ready, expected acceptance of %0d", v);
    end
  endtask

  task automatic send_frame();
    longint s0, s1;
    s0 = 0; s1 = 0;
    for (int p = 0; p < 4; p++) begin
      s0 += f0[p];
      s1 += f1[p];
    end
    exp_data_q.push_back(avg_model(s0)); exp_last_q.push_back(1'b0);
    exp_data_q.push_back(avg_model(s1)); exp_last_q.push_back(1'b1);
    for (int p = 0; p < 4; p++) begin
      send_sample(f0[p]);
      send_sample(f1[p]);
    end
    check("out_valid_after_frame", out_valid, 1);
    check("in_ready_after_frame", in_ready, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_data_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_data_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_got(input string name, input int a, input int b);
    if (got_q.size() < 2) begin
      errors++;
      $display("FAIL %s: got %0d outputs, expected 2", name, got_q.size());
      got_q.delete();
    end else begin
      check(name, got_q.pop_front(), a);
      check(name, got_q.pop_front(), b);
    end
  endtask

  task automatic fill(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    f0[0] = DW'(a0); f0[1] = DW'(a1); f0[2] = DW'(a2); f0[3] = DW'(a3);
    f1[0] = DW'(b0); f1[1] = DW'(b1); f1[2] = DW'(b2); f1[3] = DW'(b3);
  endtask

  initial begin
    // Pin the model with hand-computed averages
    check("model_basic", avg_model(16), 4);
    check("model_round_pos", avg_model(3), 1);
    check("model_round_neg", avg_model(-7), -2);
    check("model_full_pos", avg_model(131068), 32767);
    check("model_full_neg", avg_model(-131072), -32768);

    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom);
      in_data   = DW'($urandom);
      out_ready = 1'($urandom);
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1);

    // Basic frame
    fill(4, 4, 4, 4, 8, 8, 8, 8);
    send_frame();
    drain();
    expect_got("basic", 4, 8);

    // Rounding, issued back-to-back
    fill(1, 1, 1, 0, -2, -2, -2, -1);
    send_frame();
    drain();
    expect_got("rounding", 1, -2);

    // Full scale both polarities
    fill(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
    send_frame();
    drain();
    expect_got("full_pos", 32767, 32767);
    fill(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    send_frame();
    drain();
    expect_got("full_neg", -32768, -32768);

    // Backpressure with in_valid pushing 99 during emit
    out_ready = 1'b0;
    fill(4, 4, 4, 4, 8, 8, 8, 8);
    send_frame();
    in_data  = DW'(99);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, 4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    expect_got("backpressure", 4, 8);
    send_frame();
    drain();
    expect_got("after_backpressure", 4, 8);

    // Reset mid-frame discards partial sums
    send_sample(DW'(100)); send_sample(DW'(100));
    send_sample(DW'(100)); send_sample(DW'(100));
    rst = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_frame();
    drain();
    expect_got("mid_frame_reset", 4, 8);

    check("scoreboard_empty", exp_data_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
